// File: rtl/muldiv_hilo_ctrl_pkg.sv
// muldiv_hilo_ctrl_pkg: shared op codes, FSM encoding and data width for the mul/div sequencer
package muldiv_hilo_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam logic [4:0] OP_MULT  = 5'b10010;
  localparam logic [4:0] OP_MULTU = 5'b10011;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIVZ} state_e;
  function automatic logic [DATA_W-1:0] abs_s(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_hilo_ctrl_div_iter_core.sv
// muldiv_hilo_ctrl_div_iter_core: unsigned radix-2 restoring divider, one quotient bit per cycle
module muldiv_hilo_ctrl_div_iter_core
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int ITERS = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              run_o,
  output logic              last_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);
  localparam int CW = $clog2(ITERS);
  logic [CW-1:0]     cnt_q;
  logic              run_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_W:0]   sh, diff;
  logic              ge;
  // one shift-subtract step; outputs carry the value after the current iteration
  always_comb begin
    sh     = {rem_q, quo_q[DATA_W-1]};
    diff   = sh - {1'b0, dvs_q};
    ge     = ~diff[DATA_W];
    rem_o  = ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
    quot_o = {quo_q[DATA_W-2:0], ge};
    last_o = run_q && (cnt_q == '0);
    run_o  = run_q;
  end
  // load operands on start, then iterate until the counter expires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (flush_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= CW'(ITERS - 1);
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (run_q) begin
      run_q <= ~last_o;
      cnt_q <= cnt_q - 1'b1;
      rem_q <= rem_o;
      quo_q <= quot_o;
    end
  end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: mul/div sequencer owning HI/LO; MULDIV_EARLY_OUT_EN enables the divide early-out
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [4:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q, a_abs, b_abs, div_q, div_r, q_fix, r_fix;
  logic                sgn_q, is_mul, is_div, accept, setup, div_go, div_run, div_last;
  logic                eo_q, eo_hit;
  logic [2:0]          cnt_q;
  logic [2*DATA_W-1:0] prod, res;
  logic signed [2*DATA_W-1:0] ps;
  assign is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign accept = (state_q == S_IDLE) && start_i && (is_mul || is_div) && !flush_i;
  assign a_abs  = abs_s(a_q, sgn_q);
  assign b_abs  = abs_s(b_q, sgn_q);
  assign setup  = (state_q == S_DIV) && !div_run && !eo_q;
  assign div_go = setup && !flush_i && !eo_hit;
`ifdef MULDIV_EARLY_OUT_EN
  assign eo_hit = a_abs < b_abs;
  // remember a short-circuited divide so it commits the cycle after setup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) eo_q <= 1'b0;
    else     eo_q <= setup && eo_hit && !flush_i;
  end
`else
  assign eo_hit = 1'b0;
  assign eo_q   = 1'b0;
`endif
  muldiv_hilo_ctrl_div_iter_core #(.ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_go),
    .flush_i   (flush_i),
    .dividend_i(a_abs),
    .divisor_i (b_abs),
    .run_o     (div_run),
    .last_o    (div_last),
    .quot_o    (div_q),
    .rem_o     (div_r)
  );
  // latch operands on accept and count down the multiplier latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= src_a_i;
      b_q   <= src_b_i;
      sgn_q <= (op_i == OP_MULT) || (op_i == OP_DIV);
      cnt_q <= 3'(MUL_LAT - 1);
    end else if (state_q == S_MUL) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  // next state: flush beats everything, a commit returns to idle
  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = S_IDLE;
    else if (accept) state_d = is_mul ? S_MUL : (src_b_i == '0 ? S_DIVZ : S_DIV);
    else if (done_o) state_d = S_IDLE;
  end
  // outputs: stall, commit strobe and the value committed to {hi,lo}
  always_comb begin
    ps     = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) * $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
    prod   = sgn_q ? ps : {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    q_fix  = (sgn_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -div_q : div_q;
    r_fix  = (sgn_q && a_q[DATA_W-1]) ? -div_r : div_r;
    busy_o = state_q != S_IDLE;
    done_o = !flush_i && (((state_q == S_MUL) && (cnt_q == '0)) || (state_q == S_DIVZ) ||
                          ((state_q == S_DIV) && (div_last || eo_q)));
    res    = (state_q == S_MUL)  ? prod :
             (state_q == S_DIVZ) ? {a_q, {DATA_W{1'b1}}} :
             eo_q                ? {a_q, {DATA_W{1'b0}}} : {r_fix, q_fix};
  end
  // HI/LO: a result commit overrides any same-edge direct write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done_o) begin
      {hi_q, lo_q} <= res;
    end else begin
      if (hi_we_i) hi_q <= wdata_i;
      if (lo_we_i) lo_q <= wdata_i;
    end
  end
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: randomized scoreboard bench for the mul/div HI/LO sequencer
module tb_muldiv_hilo_ctrl;
  localparam int MUL_LAT = 2;
  localparam logic [4:0] MULT = 5'b10010, MULTU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, flush = 0, hi_we = 0, lo_we = 0, busy, done;
  logic [4:0]  op = 0;
  logic [31:0] src_a = 0, src_b = 0, wdata = 0, hi, lo, m_hi = 0, m_lo = 0;
  int cyc = 0, pass = 0, total = 0;
  exp_t sb[$];

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .src_a_i(src_a), .src_b_i(src_b),
    .flush_i(flush), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (o == MULT) return 64'(sa * sb_);
    if (o == MULTU) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == DIVU) return {a % b, a / b};
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_of(input logic [4:0] o, input logic [31:0] b);
    if (o == MULT || o == MULTU) return MUL_LAT;
    return (b == 0) ? 1 : 33;
  endfunction

  // mode: 0 plain, 1 stray start while busy, 2 lo_we on commit edge, 3 flush at iteration 10, 4 hi_we with start
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t e;
    logic [63:0] r;
    int lat, blen;
    lat = lat_of(o, b);
    r = ref_res(o, a, b);
    start = 1; op = o; src_a = a; src_b = b;
    if (mode == 4) begin hi_we = 1; wdata = 32'h55; end
    @(posedge clk); #1;
    start = 0; hi_we = 0;
    chk("accept_busy", busy, 1);
    if (mode == 4) chk("hi_we_with_start", hi, 32'h55);
    if (mode != 3) begin
      e.hi = r[63:32]; e.lo = r[31:0]; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
      m_hi = r[63:32]; m_lo = r[31:0];
    end
    blen = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      blen++;
      if (mode == 1 && k == 5) begin start = 1; op = MULT; end
      if (mode == 2 && k == lat) begin lo_we = 1; wdata = 32'hDEAD_BEEF; end
      if (mode == 3 && k == 11) flush = 1;
      @(posedge clk); #1;
      start = 0; lo_we = 0; flush = 0;
    end
    chk("busy_len", blen, (mode == 3) ? 11 : lat);
  endtask

  // monitor: every done pulse must match the oldest expected commit
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.acc + 1, e.lat);
        @(posedge clk); #1;
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
      end
    end
  end

  initial begin
    logic [4:0] ops [4];
    logic [31:0] a, b;
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    start = 1; op = 5'b00000;
    @(posedge clk); #1; start = 0;
    chk("bad_op_ignored", busy, 0);
    @(negedge clk);
    start = 1; op = MULT; flush = 1;
    @(posedge clk); #1; start = 0; flush = 0;
    chk("flush_blocks_start", busy, 0);
    lo_we = 1; wdata = 5;
    @(posedge clk); #1; lo_we = 0;
    chk("mtlo_idle", lo, 5);
    m_lo = 5;
    @(negedge clk);
    run_op(MULT, 32'hFFFF_FFFE, 3, 0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(DIV, -32'sd7, 2, 0);
    run_op(DIVU, 7, 2, 0);
    run_op(DIV, 32'h1234, 0, 0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(DIVU, $urandom, $urandom | 1, 3);
    chk("flush_hi_kept", hi, m_hi);
    chk("flush_lo_kept", lo, m_lo);
    run_op(MULT, 5, 32'hFFFF_FFFA, 4);
    run_op(DIV, $urandom, 32'hFFFF_FF03, 2);
    run_op(DIVU, 100, 7, 1);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000));
      run_op(ops[$urandom_range(0, 3)], a, b, 0);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
